// File: rtl/esp_uart_core.sv
// UART engine with TX/RX FIFOs and valid/ready byte streams.
// Define ESP_UART_PARITY_EN to add an even-parity bit to every frame.
module esp_uart_core #(
    parameter int  CLK_HZ     = 50000000,
    parameter int  BAUD       = 115200,
    parameter int  DATA_BITS  = 8,
    parameter int  FIFO_DEPTH = 16,
    localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                 clk_clk,
    input  logic                 reset_reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic [LW-1:0]        tx_level,
    output logic [LW-1:0]        rx_level,
    output logic                 rx_overrun,
    output logic                 rx_frame_err,
    output logic                 rx_parity_err,
    input  logic                 err_clr,
    input  logic                 esp_uart_rxd,
    output logic                 esp_uart_txd
);
    localparam int DIV = (CLK_HZ + BAUD / 2) / BAUD;
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = $clog2(DIV);
    localparam int BW  = $clog2(DATA_BITS);

    typedef enum logic [2:0] {
        TX_IDLE, TX_START, TX_DATA,
`ifdef ESP_UART_PARITY_EN
        TX_PAR,
`endif
        TX_STOP
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA,
`ifdef ESP_UART_PARITY_EN
        RX_PAR,
`endif
        RX_STOP, RX_BRK
    } rx_state_t;

    logic [DATA_BITS-1:0] tx_mem [FIFO_DEPTH];
    logic [AW-1:0]        tx_wr, tx_rd;
    logic                 tx_push, tx_pop;

    assign tx_ready = tx_level != LW'(FIFO_DEPTH);
    assign tx_push  = tx_valid & tx_ready;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tx_wr    <= '0;
            tx_rd    <= '0;
            tx_level <= '0;
        end else begin
            if (tx_push) tx_wr <= tx_wr + 1'b1;
            if (tx_pop)  tx_rd <= tx_rd + 1'b1;
            tx_level <= tx_level + LW'(tx_push) - LW'(tx_pop);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (tx_push) tx_mem[tx_wr] <= tx_data;
    end

    tx_state_t            tx_state, tx_nstate;
    logic [CW-1:0]        tx_cnt, tx_cnt_n;
    logic [BW-1:0]        tx_bit, tx_bit_n;
    logic [DATA_BITS-1:0] tx_word, tx_word_n;
    logic                 txd_n, tx_tick;

    assign tx_tick = tx_cnt == CW'(DIV - 1);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            tx_state     <= TX_IDLE;
            tx_cnt       <= '0;
            tx_bit       <= '0;
            tx_word      <= '0;
            esp_uart_txd <= 1'b1;
        end else begin
            tx_state     <= tx_nstate;
            tx_cnt       <= tx_cnt_n;
            tx_bit       <= tx_bit_n;
            tx_word      <= tx_word_n;
            esp_uart_txd <= txd_n;
        end
    end

    // STOP chains straight into START when more words are queued
    always_comb begin
        tx_nstate = tx_state;
        tx_cnt_n  = tx_cnt + 1'b1;
        tx_bit_n  = tx_bit;
        tx_word_n = tx_word;
        tx_pop    = 1'b0;
        txd_n     = 1'b1;
        unique case (tx_state)
            TX_IDLE: begin
                tx_cnt_n = '0;
                if (tx_level != '0) begin
                    tx_nstate = TX_START;
                    tx_pop    = 1'b1;
                    tx_word_n = tx_mem[tx_rd];
                end
            end
            TX_START: begin
                txd_n = 1'b0;
                if (tx_tick) begin
                    tx_cnt_n  = '0;
                    tx_bit_n  = '0;
                    tx_nstate = TX_DATA;
                end
            end
            TX_DATA: begin
                txd_n = tx_word[tx_bit];
                if (tx_tick) begin
                    tx_cnt_n = '0;
                    tx_bit_n = tx_bit + 1'b1;
                    if (tx_bit == BW'(DATA_BITS - 1)) begin
`ifdef ESP_UART_PARITY_EN
                        tx_nstate = TX_PAR;
`else
                        tx_nstate = TX_STOP;
`endif
                    end
                end
            end
`ifdef ESP_UART_PARITY_EN
            TX_PAR: begin
                txd_n = ^tx_word;
                if (tx_tick) begin
                    tx_cnt_n  = '0;
                    tx_nstate = TX_STOP;
                end
            end
`endif
            TX_STOP: begin
                if (tx_tick) begin
                    tx_cnt_n = '0;
                    if (tx_level != '0) begin
                        tx_nstate = TX_START;
                        tx_pop    = 1'b1;
                        tx_word_n = tx_mem[tx_rd];
                    end else begin
                        tx_nstate = TX_IDLE;
                    end
                end
            end
            default: tx_nstate = TX_IDLE;
        endcase
    end

    // Synchroniser resets low so a line held low is never taken as a start edge
    logic rx_s1, rx_s2, rx_s3;

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_s1 <= 1'b0;
            rx_s2 <= 1'b0;
            rx_s3 <= 1'b0;
        end else begin
            rx_s1 <= esp_uart_rxd;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    rx_state_t            rx_state, rx_nstate;
    logic [CW-1:0]        rx_cnt, rx_cnt_n;
    logic [BW-1:0]        rx_bit, rx_bit_n;
    logic [DATA_BITS-1:0] rx_word, rx_word_n;
    logic                 rx_done, rx_done_n;
    logic                 rx_stop, rx_stop_n;
    logic                 rx_tick, rx_bad_par;
`ifdef ESP_UART_PARITY_EN
    logic                 rx_pbit, rx_pbit_n;
`endif

    assign rx_tick = rx_cnt == CW'(DIV - 1);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_word  <= '0;
            rx_done  <= 1'b0;
            rx_stop  <= 1'b0;
        end else begin
            rx_state <= rx_nstate;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_word  <= rx_word_n;
            rx_done  <= rx_done_n;
            rx_stop  <= rx_stop_n;
        end
    end

`ifdef ESP_UART_PARITY_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset) rx_pbit <= 1'b0;
        else             rx_pbit <= rx_pbit_n;
    end
    assign rx_bad_par = (^rx_word) ^ rx_pbit;
`else
    assign rx_bad_par = 1'b0;
`endif

    always_comb begin
        rx_nstate = rx_state;
        rx_cnt_n  = rx_cnt + 1'b1;
        rx_bit_n  = rx_bit;
        rx_word_n = rx_word;
        rx_done_n = 1'b0;
        rx_stop_n = rx_stop;
`ifdef ESP_UART_PARITY_EN
        rx_pbit_n = rx_pbit;
`endif
        unique case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (rx_s3 & ~rx_s2) rx_nstate = RX_START;
            end
            RX_START: begin
                if (rx_cnt == CW'(DIV / 2 - 1)) begin
                    rx_cnt_n  = '0;
                    rx_bit_n  = '0;
                    rx_nstate = rx_s2 ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_cnt_n  = '0;
                    rx_bit_n  = rx_bit + 1'b1;
                    rx_word_n = {rx_s2, rx_word[DATA_BITS-1:1]};
                    if (rx_bit == BW'(DATA_BITS - 1)) begin
`ifdef ESP_UART_PARITY_EN
                        rx_nstate = RX_PAR;
`else
                        rx_nstate = RX_STOP;
`endif
                    end
                end
            end
`ifdef ESP_UART_PARITY_EN
            RX_PAR: begin
                if (rx_tick) begin
                    rx_cnt_n  = '0;
                    rx_pbit_n = rx_s2;
                    rx_nstate = RX_STOP;
                end
            end
`endif
            RX_STOP: begin
                if (rx_tick) begin
                    rx_cnt_n  = '0;
                    rx_done_n = 1'b1;
                    rx_stop_n = rx_s2;
                    rx_nstate = rx_s2 ? RX_IDLE : RX_BRK;
                end
            end
            RX_BRK: begin
                rx_cnt_n = '0;
                if (rx_s2) rx_nstate = RX_IDLE;
            end
            default: rx_nstate = RX_IDLE;
        endcase
    end

    logic [DATA_BITS-1:0] rx_mem [FIFO_DEPTH];
    logic [AW-1:0]        rx_wr, rx_rd;
    logic                 rx_push, rx_pop, rx_full, rx_good;

    assign rx_valid = rx_level != '0;
    assign rx_full  = rx_level == LW'(FIFO_DEPTH);
    assign rx_pop   = rx_valid & rx_ready;
    assign rx_data  = rx_valid ? rx_mem[rx_rd] : '0;
    assign rx_good  = rx_done & rx_stop & ~rx_bad_par;
    assign rx_push  = rx_good & (~rx_full | rx_pop);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_wr    <= '0;
            rx_rd    <= '0;
            rx_level <= '0;
        end else begin
            if (rx_push) rx_wr <= rx_wr + 1'b1;
            if (rx_pop)  rx_rd <= rx_rd + 1'b1;
            rx_level <= rx_level + LW'(rx_push) - LW'(rx_pop);
        end
    end

    always_ff @(posedge clk_clk) begin
        if (rx_push) rx_mem[rx_wr] <= rx_word;
    end

    // A new error wins over a clear landing in the same cycle
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            rx_overrun   <= 1'b0;
            rx_frame_err <= 1'b0;
        end else begin
            if (rx_good & rx_full & ~rx_pop) rx_overrun <= 1'b1;
            else if (err_clr)                rx_overrun <= 1'b0;
            if (rx_done & ~rx_stop)          rx_frame_err <= 1'b1;
            else if (err_clr)                rx_frame_err <= 1'b0;
        end
    end

`ifdef ESP_UART_PARITY_EN
    always_ff @(posedge clk_clk) begin
        if (reset_reset)                      rx_parity_err <= 1'b0;
        else if (rx_done & rx_stop & rx_bad_par) rx_parity_err <= 1'b1;
        else if (err_clr)                     rx_parity_err <= 1'b0;
    end
`else
    assign rx_parity_err = 1'b0;
`endif

endmodule
